// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path widths, reset vector and fetch FSM state type
package cpu_pkg;

    localparam int ADDR_W  = 20;
    localparam int INSTR_W = 20;
    localparam logic [ADDR_W-1:0] RESET_VEC = 20'h00000;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // Word-addressed sequential step; wraps modulo 2^ADDR_W with no flag.
    function automatic logic [ADDR_W-1:0] nextPc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - imem request/response, branch redirect and decode handoff bundle
interface pc_fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               br_valid;
    logic [ADDR_W-1:0]  br_target;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, br_valid, br_target, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, br_valid, br_target, dec_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 1-entry valid/ready holding stage for {instr, pc} with flush
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               inValid,
    input  logic [INSTR_W-1:0] inInstr,
    input  logic [ADDR_W-1:0]  inPc,
    input  logic               outReady,
    output logic               outValid,
    output logic [INSTR_W-1:0] outInstr,
    output logic [ADDR_W-1:0]  outPc
);

    // The producer only loads when empty or draining, so a load always wins over a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outInstr <= '0;
            outPc    <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (inValid) begin
            outValid <= 1'b1;
            outInstr <= inInstr;
            outPc    <= inPc;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner, single-outstanding imem fetch FSM and redirect handling
module pc_fetch_unit
    import cpu_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    pc_fetch_unit_if.master  bus
);

    fetch_state_t      state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext;
    logic              drop, dropNext;
    logic              reqValid;
    logic              reqFire;
    logic              rspTake;
    logic              bufLoad;

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = pc;
    assign reqFire            = reqValid & bus.imem_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= REQ;
            pc    <= RESET_VEC;
            drop  <= 1'b0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            drop  <= dropNext;
        end
    end

    // A redirect overrides everything; drop marks an in-flight response that belongs to the old path.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        dropNext  = drop;
        if (bus.br_valid) begin
            pcNext = bus.br_target;
            if (state == WAIT) begin
                if (bus.imem_rsp_valid) begin
                    stateNext = REQ;
                    dropNext  = 1'b0;
                end else begin
                    dropNext  = 1'b1;
                end
            end else if (reqFire) begin
                stateNext = WAIT;
                dropNext  = 1'b1;
            end
        end else begin
            case (state)
                REQ: begin
                    if (reqFire) stateNext = WAIT;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        stateNext = REQ;
                        if (drop) dropNext = 1'b0;
                        else      pcNext   = nextPc(pc);
                    end
                end
                default: stateNext = REQ;
            endcase
        end
    end

    always_comb begin
        reqValid = 1'b0;
        rspTake  = 1'b0;
        bufLoad  = 1'b0;
        case (state)
            REQ:  reqValid = rst_n & (~bus.dec_valid | bus.dec_ready);
            WAIT: begin
                rspTake = bus.imem_rsp_valid;
                bufLoad = rspTake & ~drop & ~bus.br_valid;
            end
            default: ;
        endcase
    end

    fetch_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.br_valid),
        .inValid  (bufLoad),
        .inInstr  (bus.imem_rsp_data),
        .inPc     (pc),
        .outReady (bus.dec_ready),
        .outValid (bus.dec_valid),
        .outInstr (bus.dec_instr),
        .outPc    (bus.dec_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed bench for pc_fetch_unit with an addr-as-data instruction memory
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;
    int   memDelay;
    int   n;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: response appears memDelay+1 cycles after the accepting edge, data = address.
    initial begin : imem_model
        logic              pend;
        logic [ADDR_W-1:0] pendAddr;
        int                cd;
        pend = 1'b0;
        pendAddr = '0;
        cd = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend = 1'b0;
                bus.imem_rsp_valid = 1'b0;
            end else begin
                if (pend && cd == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = pendAddr;
                    pend = 1'b0;
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    if (pend) cd = cd - 1;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend = 1'b1;
                    pendAddr = bus.imem_req_addr;
                    cd = memDelay;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared = nCompared + 1;
        if (got !== exp) begin
            nMismatched = nMismatched + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic waitDec(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt = cnt + 1;
        end while (!bus.dec_valid && cnt < 20);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        memDelay    = 0;
        rst_n          = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_target  = '0;
        bus.dec_ready  = 1'b1;
        bus.imem_req_ready = 1'b1;

        step();
        step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_dec_instr", 32'(bus.dec_instr), 32'd0);
        chk("rst_dec_pc", 32'(bus.dec_pc), 32'd0);
        chk("rst_req_addr", 32'(bus.imem_req_addr), 32'(RESET_VEC));
        rst_n = 1'b1;

        // Sequential stream, one instruction every two cycles.
        for (int i = 0; i < 4; i++) begin
            waitDec(n);
            chk("t1_gap", 32'(n), 32'd2);
            chk("t1_pc", 32'(bus.dec_pc), 32'(i));
            chk("t1_instr", 32'(bus.dec_instr), 32'(i));
        end

        // Decode stall holds the buffer and blocks new requests.
        bus.dec_ready = 1'b0;
        doReset();
        waitDec(n);
        chk("t2_first_gap", 32'(n), 32'd2);
        chk("t2_first_pc", 32'(bus.dec_pc), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", 32'(bus.dec_valid), 32'd1);
            chk("t2_hold_instr", 32'(bus.dec_instr), 32'd0);
            chk("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
            chk("t2_pc_held", 32'(bus.imem_req_addr), 32'd1);
        end
        bus.dec_ready = 1'b1;
        waitDec(n);
        chk("t2_resume_gap", 32'(n), 32'd2);
        chk("t2_resume_pc", 32'(bus.dec_pc), 32'd1);

        // Redirect while waiting on a slow response.
        memDelay = 2;
        step();
        chk("t3_wait_noreq", 32'(bus.imem_req_valid), 32'd0);
        bus.br_valid  = 1'b1;
        bus.br_target = 20'h00100;
        step();
        bus.br_valid = 1'b0;
        memDelay = 0;
        chk("t3_still_wait", 32'(bus.imem_req_valid), 32'd0);
        chk("t3_addr", 32'(bus.imem_req_addr), 32'h100);
        chk("t3_no_dec", 32'(bus.dec_valid), 32'd0);
        waitDec(n);
        chk("t3_gap", 32'(n), 32'd4);
        chk("t3_pc", 32'(bus.dec_pc), 32'h100);
        chk("t3_instr", 32'(bus.dec_instr), 32'h100);

        // Redirect coincident with the response.
        step();
        chk("t4_pre_dec", 32'(bus.dec_valid), 32'd0);
        bus.br_valid  = 1'b1;
        bus.br_target = 20'h00040;
        step();
        bus.br_valid = 1'b0;
        chk("t4_no_old_dec", 32'(bus.dec_valid), 32'd0);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_addr", 32'(bus.imem_req_addr), 32'h40);
        waitDec(n);
        chk("t4_gap", 32'(n), 32'd2);
        chk("t4_pc", 32'(bus.dec_pc), 32'h40);
        chk("t4_instr", 32'(bus.dec_instr), 32'h40);

        // Redirect in REQ as the old request is accepted, then wrap at the top of the address space.
        bus.br_valid  = 1'b1;
        bus.br_target = 20'hFFFFF;
        step();
        bus.br_valid = 1'b0;
        chk("t5_flushed", 32'(bus.dec_valid), 32'd0);
        chk("t5_wait", 32'(bus.imem_req_valid), 32'd0);
        chk("t5_addr", 32'(bus.imem_req_addr), 32'hFFFFF);
        waitDec(n);
        chk("t5_gap", 32'(n), 32'd3);
        chk("t5_pc_top", 32'(bus.dec_pc), 32'hFFFFF);
        chk("t5_instr_top", 32'(bus.dec_instr), 32'hFFFFF);
        waitDec(n);
        chk("t5_wrap_gap", 32'(n), 32'd2);
        chk("t5_pc_wrap", 32'(bus.dec_pc), 32'd0);
        chk("t5_instr_wrap", 32'(bus.dec_instr), 32'd0);

        // One-cycle reset while an instruction sits in the buffer.
        bus.dec_ready = 1'b0;
        step();
        chk("t6_held", 32'(bus.dec_valid), 32'd1);
        chk("t6_stall_noreq", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_pc_before", 32'(bus.imem_req_addr), 32'd1);
        rst_n = 1'b0;
        step();
        chk("t6_dec_cleared", 32'(bus.dec_valid), 32'd0);
        chk("t6_req_gated", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_addr_reset", 32'(bus.imem_req_addr), 32'(RESET_VEC));
        bus.dec_ready = 1'b1;
        rst_n = 1'b1;
        waitDec(n);
        chk("t6_gap", 32'(n), 32'd2);
        chk("t6_pc0", 32'(bus.dec_pc), 32'd0);
        waitDec(n);
        chk("t6_gap2", 32'(n), 32'd2);
        chk("t6_pc1", 32'(bus.dec_pc), 32'd1);
        chk("t6_instr1", 32'(bus.dec_instr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
